// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its decode interface.
package fetch_stage_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DISCARD = 2'd1,
        FAULT   = 2'd2
    } fetch_state_t;

    // Control coming back from decode/execute into fetch.
    typedef struct packed {
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        stall;
    } fetch_in_type;

    // What fetch presents to decode.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        misaligned;
    } fetch_out_type;

    // Decode consumes exactly what fetch presents.
    typedef fetch_out_type decode_in_type;

    // RV32I without the C extension requires word-aligned targets.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} pairs; flush empties it in one cycle.
module fetch_fifo
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   i_clock,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic [31:0]            i_pc,
    input  logic [31:0]            i_instr,
    output logic [31:0]            o_head_pc,
    output logic [31:0]            o_head_instr,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [31:0]   r_pc_mem    [DEPTH];
    logic [31:0]   r_instr_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    // Storage write at the tail; storage needs no reset because count gates visibility.
    always_ff @(posedge i_clock) begin
        if (i_push && !i_flush) begin
            r_pc_mem[r_wr_ptr]    <= i_pc;
            r_instr_mem[r_wr_ptr] <= i_instr;
        end
    end

    // Pointer and occupancy tracking; flush wins over push/pop.
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    assign o_head_pc    = r_pc_mem[r_rd_ptr];
    assign o_head_instr = r_instr_mem[r_rd_ptr];
    assign o_full       = (r_count == DEPTH_C);
    assign o_empty      = (r_count == '0);
    assign o_count      = r_count;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: one outstanding memory read, prefetch FIFO, redirect handling.
//
// Handshakes: imem_valid/imem_addr are registered and held until a cycle with
// imem_ready=1, which completes the request and carries imem_rdata. Towards decode,
// valid marks a real entry; it is consumed in any cycle with valid & !stall & !redirect.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic         clock,
    input  logic         reset,
    output logic         imem_valid,
    output logic [31:0]  imem_addr,
    input  logic         imem_ready,
    input  logic [31:0]  imem_rdata,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    input  logic         stall,
    output logic         valid,
    output logic [31:0]  pc,
    output logic [31:0]  instr,
    output logic         misaligned,
    output fetch_state_t dbg_state
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_in_type  w_in;
    fetch_out_type w_out;

    fetch_state_t  r_state, w_state_next;
    logic          r_imem_valid, w_imem_valid_next;
    logic [31:0]   r_imem_addr, w_imem_addr_next;
    logic [31:0]   r_target, w_target_next;

    logic          w_push, w_pop, w_flush;
    logic          w_full, w_empty;
    logic [CW-1:0] w_count, w_count_next;
    logic [31:0]   w_head_pc, w_head_instr;
    logic          w_outstanding_after;

    assign w_in = '{redirect: redirect, redirect_pc: redirect_pc, stall: stall};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clock      (clock),
        .i_rst_n      (reset),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_flush      (w_flush),
        .i_pc         (r_imem_addr),
        .i_instr      (imem_rdata),
        .o_head_pc    (w_head_pc),
        .o_head_instr (w_head_instr),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_count      (w_count)
    );

    // Next-state, request and FIFO control; a redirect overrides everything else.
    always_comb begin
        w_state_next      = r_state;
        w_imem_valid_next = r_imem_valid;
        w_imem_addr_next  = r_imem_addr;
        w_target_next     = r_target;
        w_push            = 1'b0;
        w_pop             = 1'b0;
        w_flush           = 1'b0;
        w_count_next      = w_count;
        // A request survives this cycle only if it was not completed now.
        w_outstanding_after = r_imem_valid && !imem_ready;

        if (w_in.redirect) begin
            w_flush       = 1'b1;
            w_target_next = w_in.redirect_pc;
            if (w_outstanding_after) begin
                // Keep the old request on the bus until memory finishes it.
                w_state_next = DISCARD;
            end else if (is_misaligned(w_in.redirect_pc[1:0])) begin
                w_state_next      = FAULT;
                w_imem_valid_next = 1'b0;
            end else begin
                w_state_next      = FETCH;
                w_imem_valid_next = 1'b1;
                w_imem_addr_next  = w_in.redirect_pc;
            end
        end else begin
            case (r_state)
                FETCH: begin
                    w_pop        = !w_empty && !w_in.stall;
                    w_push       = r_imem_valid && imem_ready && (!w_full || w_pop);
                    w_count_next = w_count + CW'(w_push) - CW'(w_pop);
                    if (w_push) begin
                        w_imem_addr_next = r_imem_addr + 32'd4;
                    end
                    // Only request when the word is guaranteed a slot on arrival.
                    if (w_push || !r_imem_valid) begin
                        w_imem_valid_next = (w_count_next < DEPTH_C);
                    end
                end
                DISCARD: begin
                    if (imem_ready) begin
                        if (is_misaligned(r_target[1:0])) begin
                            w_state_next      = FAULT;
                            w_imem_valid_next = 1'b0;
                        end else begin
                            w_state_next      = FETCH;
                            w_imem_valid_next = 1'b1;
                            w_imem_addr_next  = r_target;
                        end
                    end
                end
                FAULT: begin
                    w_imem_valid_next = 1'b0;
                end
                default: begin
                    w_state_next      = FETCH;
                    w_imem_valid_next = 1'b0;
                end
            endcase
        end
    end

    // State and request registers; reset abandons any outstanding request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= FETCH;
            r_imem_valid <= 1'b0;
            r_imem_addr  <= RESET_PC;
            r_target     <= 32'd0;
        end else begin
            r_state      <= w_state_next;
            r_imem_valid <= w_imem_valid_next;
            r_imem_addr  <= w_imem_addr_next;
            r_target     <= w_target_next;
        end
    end

    // Decode-facing view: a fault entry, the FIFO head, or a nop bubble.
    always_comb begin
        w_out = '{valid: 1'b0, pc: 32'd0, instr: NOP_INSTR, misaligned: 1'b0};
        if (r_state == FAULT) begin
            w_out.valid      = 1'b1;
            w_out.misaligned = 1'b1;
            w_out.pc         = r_target;
        end else if (!w_empty) begin
            w_out.valid = 1'b1;
            w_out.pc    = w_head_pc;
            w_out.instr = w_head_instr;
        end
    end

    assign imem_valid = r_imem_valid;
    assign imem_addr  = r_imem_addr;
    assign valid      = w_out.valid;
    assign pc         = w_out.pc;
    assign instr      = w_out.instr;
    assign misaligned = w_out.misaligned;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an expected-queue scoreboard on the decode side.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic         clock;
  logic         reset;
  logic         imem_valid;
  logic [31:0]  imem_addr;
  logic         imem_ready;
  logic [31:0]  imem_rdata;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         stall;
  logic         valid;
  logic [31:0]  pc;
  logic [31:0]  instr;
  logic         misaligned;
  fetch_state_t dbg_state;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  fetch_stage #(.RESET_PC(32'h0000_0100), .DEPTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_valid  (imem_valid),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .valid       (valid),
    .pc          (pc),
    .instr       (instr),
    .misaligned  (misaligned),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: the word stored at address a
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic expect_pc(input logic [31:0] p);
    exp_q.push_back({p, mem_word(p)});
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor: every instruction decode actually takes must match the queue head
  always @(negedge clock) begin
    if (reset && valid && !misaligned && !stall && !redirect) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: actual pc=%h instr=%h expected none", pc, instr);
      end else begin
        chk("sb_entry", {pc, instr}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Driver: directed sequence, one input update per cycle just after the rising edge
  initial begin
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; imem_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    mid();
    chk("rst_imem_valid", 64'(imem_valid), 64'd0);
    chk("rst_imem_addr", 64'(imem_addr), 64'h100);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_pc", 64'(pc), 64'd0);
    chk("rst_instr", 64'(instr), 64'h13);
    chk("rst_misaligned", 64'(misaligned), 64'd0);

    // Ramp from RESET_PC, then redirect while 108 completes
    expect_pc(32'h100);
    nxt(); reset = 1'b1;
    mid(); chk("c0_imem_valid", 64'(imem_valid), 64'd0);
    nxt(); mid();
    chk("c1_imem_valid", 64'(imem_valid), 64'd1);
    chk("c1_addr", 64'(imem_addr), 64'h100);
    chk("c1_valid", 64'(valid), 64'd0);
    nxt(); mid();
    chk("c2_addr", 64'(imem_addr), 64'h104);
    nxt(); redirect = 1'b1; redirect_pc = 32'h200;
    mid(); chk("c3_addr", 64'(imem_addr), 64'h108);

    // Stall fill: exactly four words buffered
    expect_pc(32'h200); expect_pc(32'h204); expect_pc(32'h208);
    expect_pc(32'h20C); expect_pc(32'h210);
    nxt(); redirect = 1'b0; stall = 1'b1;
    mid();
    chk("redir_valid_gap", 64'(valid), 64'd0);
    chk("redir_addr", 64'(imem_addr), 64'h200);
    chk("redir_imem_valid", 64'(imem_valid), 64'd1);
    for (int i = 1; i < 10; i++) begin
      nxt(); mid();
      if (i >= 4) chk("full_imem_valid", 64'(imem_valid), 64'd0);
      if (i == 9) chk("full_head", {31'd0, valid, pc}, {31'd0, 1'b1, 32'h200});
    end
    nxt(); stall = 1'b0;
    mid(); chk("release_imem_valid", 64'(imem_valid), 64'd0);
    nxt(); mid();
    chk("refill_imem_valid", 64'(imem_valid), 64'd1);
    chk("refill_addr", 64'(imem_addr), 64'h210);
    nxt(); nxt();

    // Double redirect while a request is stuck
    nxt(); imem_ready = 1'b0;
    mid(); chk("stuck_addr", 64'(imem_addr), 64'h21C);
    nxt(); redirect = 1'b1; redirect_pc = 32'h300;
    mid();
    chk("sb_drain_b", 64'(exp_q.size()), 64'd0);
    chk("stuck_imem_valid", 64'(imem_valid), 64'd1);
    nxt(); redirect_pc = 32'h400;
    mid();
    chk("discard_state", 64'(dbg_state), 64'(DISCARD));
    chk("discard_valid", 64'(valid), 64'd0);
    chk("discard_hold_addr", 64'(imem_addr), 64'h21C);
    expect_pc(32'h400);
    nxt(); redirect = 1'b0; imem_ready = 1'b1;
    mid(); chk("discard_drop_valid", 64'(valid), 64'd0);
    nxt(); mid();
    chk("after_discard_addr", 64'(imem_addr), 64'h400);
    chk("after_discard_state", 64'(dbg_state), 64'(FETCH));
    chk("after_discard_valid", 64'(valid), 64'd0);
    nxt(); mid();

    // Misaligned redirect target
    nxt(); redirect = 1'b1; redirect_pc = 32'h202;
    mid(); chk("sb_drain_c", 64'(exp_q.size()), 64'd0);
    nxt(); redirect = 1'b0;
    mid();
    chk("fault_out", {valid, misaligned, pc, instr, 30'd0},
        {1'b1, 1'b1, 32'h202, 32'h13, 30'd0});
    chk("fault_imem_valid", 64'(imem_valid), 64'd0);
    chk("fault_state", 64'(dbg_state), 64'(FAULT));
    nxt(); stall = 1'b1;
    mid();
    chk("fault_stall_out", {valid, misaligned, pc, 30'd0}, {1'b1, 1'b1, 32'h202, 30'd0});
    chk("fault_stall_imem", 64'(imem_valid), 64'd0);
    expect_pc(32'h0); expect_pc(32'h4);
    nxt(); stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h0;
    mid(); chk("fault_until_redirect", 64'(misaligned), 64'd1);
    nxt(); redirect = 1'b0;
    mid();
    chk("resume_misaligned", 64'(misaligned), 64'd0);
    chk("resume_valid", 64'(valid), 64'd0);
    chk("resume_req", {31'd0, imem_valid, imem_addr}, {31'd0, 1'b1, 32'h0});
    nxt(); mid();

    // Async reset in DISCARD, then wrap-around fetch
    nxt(); imem_ready = 1'b0;
    mid(); chk("pre_reset_addr", 64'(imem_addr), 64'h8);
    nxt(); redirect = 1'b1; redirect_pc = 32'h500;
    mid();
    nxt(); redirect = 1'b0;
    mid();
    chk("pre_reset_state", 64'(dbg_state), 64'(DISCARD));
    reset = 1'b0;
    #1;
    chk("async_imem_valid", 64'(imem_valid), 64'd0);
    chk("async_imem_addr", 64'(imem_addr), 64'h100);
    chk("async_state", 64'(dbg_state), 64'(FETCH));
    chk("async_out", {valid, misaligned, pc, instr, 30'd0}, {1'b0, 1'b0, 32'h0, 32'h13, 30'd0});
    nxt(); reset = 1'b1; imem_ready = 1'b1;
    expect_pc(32'hFFFF_FFFC); expect_pc(32'h0);
    nxt(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    mid(); chk("restart_req", {31'd0, imem_valid, imem_addr}, {31'd0, 1'b1, 32'h100});
    nxt(); redirect = 1'b0;
    mid();
    chk("wrap_req", 64'(imem_addr), 64'hFFFF_FFFC);
    chk("wrap_valid_gap", 64'(valid), 64'd0);
    nxt(); mid();
    chk("wrap_next_addr", 64'(imem_addr), 64'h0);
    nxt(); mid();
    chk("wrap_no_fault", 64'(misaligned), 64'd0);
    chk("wrap_after_addr", 64'(imem_addr), 64'h4);
    nxt(); stall = 1'b1;
    mid();
    chk("sb_final_drain", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
